// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA pipeline screen sequencer.
package vga_pkg;

   typedef enum logic [1:0] {
      SCR_MENU  = 2'd0,
      SCR_PLAY  = 2'd1,
      SCR_PAUSE = 2'd2,
      SCR_OVER  = 2'd3
   } screen_t;

   localparam int unsigned OVER_FRAMES_DEF = 120;
   localparam int unsigned CNT_W_DEF       = 8;

endpackage

// File: rtl/screen_ctrl_if.sv
// Control/status bundle between the screen sequencer and its environment.
interface screen_ctrl_if
   import vga_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic             vsync;
   logic             btn_start;
   logic             btn_pause;
   logic             game_over;
   screen_t          screen;
   logic             game_en;
   logic             game_rst;
   logic [CNT_W-1:0] over_cnt;

   modport master (
      output vsync, btn_start, btn_pause, game_over,
      input  screen, game_en, game_rst, over_cnt
   );

   modport slave (
      input  vsync, btn_start, btn_pause, game_over,
      output screen, game_en, game_rst, over_cnt
   );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a registered rising-edge pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         sync2_q <= sync2;
         rise    <= sync2 & ~sync2_q;
      end
   end

endmodule

// File: rtl/screen_ctrl.sv
// Screen sequencer: collects button/game events per frame and switches the
// active draw layer only on vsync rising edges.
module screen_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned OVER_FRAMES = OVER_FRAMES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   screen_ctrl_if.slave bus
);

   logic             start_edge;
   logic             pause_edge;
   logic             vsync_q;
   logic             frame_tick_c;
   logic             start_p;
   logic             pause_p;
   logic             over_p;
   screen_t          state_q;
   screen_t          state_d;
   logic [CNT_W-1:0] over_cnt_q;
   logic [CNT_W-1:0] over_cnt_d;
   logic             game_en_q;
   logic             game_en_d;
   logic             game_rst_q;
   logic             game_rst_d;

   btn_sync_edge u_start (.clk(clk), .rst_n(rst_n), .btn(bus.btn_start), .rise(start_edge));
   btn_sync_edge u_pause (.clk(clk), .rst_n(rst_n), .btn(bus.btn_pause), .rise(pause_edge));

   assign frame_tick_c = bus.vsync & ~vsync_q;

   // Requests live for one frame; on a tick only that cycle's event survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         start_p <= 1'b0;
         pause_p <= 1'b0;
         over_p  <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         if (frame_tick_c) begin
            start_p <= start_edge;
            pause_p <= pause_edge;
            over_p  <= bus.game_over;
         end else begin
            start_p <= start_p | start_edge;
            pause_p <= pause_p | pause_edge;
            over_p  <= over_p  | bus.game_over;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCR_MENU;
         over_cnt_q <= '0;
         game_en_q  <= 1'b0;
         game_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         over_cnt_q <= over_cnt_d;
         game_en_q  <= game_en_d;
         game_rst_q <= game_rst_d;
      end
   end

   // Next state: one decision per frame tick.
   always_comb begin
      state_d    = state_q;
      over_cnt_d = over_cnt_q;
      if (frame_tick_c) begin
         unique case (state_q)
            SCR_MENU: begin
               if (start_p) state_d = SCR_PLAY;
            end
            SCR_PLAY: begin
               if (over_p) begin
                  state_d    = SCR_OVER;
                  over_cnt_d = '0;
               end else if (pause_p) begin
                  state_d = SCR_PAUSE;
               end
            end
            SCR_PAUSE: begin
               if (start_p)      state_d = SCR_MENU;
               else if (pause_p) state_d = SCR_PLAY;
            end
            SCR_OVER: begin
               if (start_p || over_cnt_q == CNT_W'(OVER_FRAMES - 1)) begin
                  state_d    = SCR_MENU;
                  over_cnt_d = '0;
               end else if (over_cnt_q < CNT_W'(OVER_FRAMES)) begin
                  over_cnt_d = over_cnt_q + CNT_W'(1);
               end
            end
            default: state_d = SCR_MENU;
         endcase
      end
   end

   always_comb begin
      game_en_d  = (state_d == SCR_PLAY);
      game_rst_d = frame_tick_c && (state_q == SCR_MENU) && start_p;
   end

   assign bus.screen   = state_q;
   assign bus.over_cnt = over_cnt_q;
   assign bus.game_en  = game_en_q;
   assign bus.game_rst = game_rst_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// Scoreboard bench for screen_ctrl: expected output changes are queued with
// their cycle; a monitor pops and checks every observed output change.
module tb_screen_ctrl;
   import vga_pkg::*;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  scr;
      logic        en;
      logic        rst;
      logic [7:0]  cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   obs_t exp_q[$];
   obs_t prev;

   screen_ctrl_if #(.CNT_W(8)) bus ();

   screen_ctrl #(.OVER_FRAMES(3), .CNT_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t cur_obs();
      obs_t o;
      o.cyc = 32'(cyc);
      o.scr = bus.screen;
      o.en  = bus.game_en;
      o.rst = bus.game_rst;
      o.cnt = bus.over_cnt;
      return o;
   endfunction

   // Monitor: every output change must match the next queued expectation.
   always @(negedge clk) begin
      obs_t c;
      obs_t e;
      c = cur_obs();
      if (!rst_n) begin
         prev = c;
      end else if (c[11:0] != prev[11:0]) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change cyc=%0d got scr=%0d en=%0d rst=%0d cnt=%0d want no change",
                     c.cyc, c.scr, c.en, c.rst, c.cnt);
         end else begin
            e = exp_q.pop_front();
            if (c != e) begin
               bad++;
               $display("FAIL change cyc=%0d scr=%0d en=%0d rst=%0d cnt=%0d want cyc=%0d scr=%0d en=%0d rst=%0d cnt=%0d",
                        c.cyc, c.scr, c.en, c.rst, c.cnt, e.cyc, e.scr, e.en, e.rst, e.cnt);
            end
         end
         prev = c;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic frame_low(input int n);
      bus.vsync = 1'b0;
      step(n);
   endtask

   // Raise vsync; if a change is expected it appears one clk later.
   task automatic tick(input screen_t s, input logic en, input logic r,
                       input logic [7:0] c, input bit chg);
      obs_t e;
      bus.vsync = 1'b1;
      if (chg) begin
         e.cyc = 32'(cyc + 1);
         e.scr = s;
         e.en  = en;
         e.rst = r;
         e.cnt = c;
         exp_q.push_back(e);
         if (r) begin
            e.cyc = 32'(cyc + 2);
            e.rst = 1'b0;
            exp_q.push_back(e);
         end
      end
      step(3);
   endtask

   task automatic check_now(input string name, input screen_t s, input logic en,
                            input logic r, input logic [7:0] c);
      total++;
      if (bus.screen != s || bus.game_en != en || bus.game_rst != r || bus.over_cnt != c) begin
         bad++;
         $display("FAIL %s got scr=%0d en=%0d rst=%0d cnt=%0d want scr=%0d en=%0d rst=%0d cnt=%0d",
                  name, bus.screen, bus.game_en, bus.game_rst, bus.over_cnt, s, en, r, c);
      end
   endtask

   task automatic pulse_over();
      bus.game_over = 1'b1;
      step(1);
      bus.game_over = 1'b0;
   endtask

   initial begin
      bus.vsync     = 1'b1;
      bus.btn_start = 1'b0;
      bus.btn_pause = 1'b0;
      bus.game_over = 1'b0;
      step(3);
      check_now("reset", SCR_MENU, 1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;
      step(3);

      // Idle frames: nothing changes.
      repeat (5) begin
         frame_low(4);
         tick(SCR_MENU, 1'b0, 1'b0, 8'd0, 1'b0);
      end
      check_now("idle_menu", SCR_MENU, 1'b0, 1'b0, 8'd0);

      // Held start: exactly one transition into PLAY.
      frame_low(2);
      bus.btn_start = 1'b1;
      frame_low(4);
      tick(SCR_PLAY, 1'b1, 1'b1, 8'd0, 1'b1);
      repeat (2) begin
         frame_low(4);
         tick(SCR_PLAY, 1'b1, 1'b0, 8'd0, 1'b0);
      end
      bus.btn_start = 1'b0;
      check_now("held_start", SCR_PLAY, 1'b1, 1'b0, 8'd0);

      // Pause and resume, then pause and abort.
      frame_low(1); bus.btn_pause = 1'b1; frame_low(5);
      tick(SCR_PAUSE, 1'b0, 1'b0, 8'd0, 1'b1);
      bus.btn_pause = 1'b0;
      check_now("paused", SCR_PAUSE, 1'b0, 1'b0, 8'd0);
      frame_low(1); bus.btn_pause = 1'b1; frame_low(5);
      tick(SCR_PLAY, 1'b1, 1'b0, 8'd0, 1'b1);
      bus.btn_pause = 1'b0;
      frame_low(1); bus.btn_pause = 1'b1; frame_low(5);
      tick(SCR_PAUSE, 1'b0, 1'b0, 8'd0, 1'b1);
      bus.btn_pause = 1'b0;
      frame_low(1); bus.btn_start = 1'b1; frame_low(5);
      tick(SCR_MENU, 1'b0, 1'b0, 8'd0, 1'b1);
      bus.btn_start = 1'b0;
      frame_low(1); bus.btn_start = 1'b1; frame_low(5);
      tick(SCR_PLAY, 1'b1, 1'b1, 8'd0, 1'b1);
      bus.btn_start = 1'b0;

      // game_over and pause in the same frame: OVER wins, then auto-return.
      frame_low(1); bus.btn_pause = 1'b1; pulse_over(); frame_low(4);
      tick(SCR_OVER, 1'b0, 1'b0, 8'd0, 1'b1);
      bus.btn_pause = 1'b0;
      frame_low(4); tick(SCR_OVER, 1'b0, 1'b0, 8'd1, 1'b1);
      frame_low(4); tick(SCR_OVER, 1'b0, 1'b0, 8'd2, 1'b1);
      frame_low(4); tick(SCR_MENU, 1'b0, 1'b0, 8'd0, 1'b1);
      check_now("over_done", SCR_MENU, 1'b0, 1'b0, 8'd0);

      // Start edge landing on the tick cycle is deferred one frame.
      frame_low(4);
      bus.btn_start = 1'b1;
      step(3);
      tick(SCR_MENU, 1'b0, 1'b0, 8'd0, 1'b0);
      frame_low(4);
      tick(SCR_PLAY, 1'b1, 1'b1, 8'd0, 1'b1);
      bus.btn_start = 1'b0;

      // Async reset while in OVER with over_cnt=2; pending start is dropped.
      frame_low(1); pulse_over(); frame_low(4);
      tick(SCR_OVER, 1'b0, 1'b0, 8'd0, 1'b1);
      frame_low(4); tick(SCR_OVER, 1'b0, 1'b0, 8'd1, 1'b1);
      frame_low(4); tick(SCR_OVER, 1'b0, 1'b0, 8'd2, 1'b1);
      check_now("over_cnt2", SCR_OVER, 1'b0, 1'b0, 8'd2);
      frame_low(2);
      bus.btn_start = 1'b1;
      step(4);
      #2 rst_n = 1'b0;
      #1 check_now("async_reset", SCR_MENU, 1'b0, 1'b0, 8'd0);
      bus.btn_start = 1'b0;
      step(3);
      rst_n = 1'b1;
      frame_low(4);
      tick(SCR_MENU, 1'b0, 1'b0, 8'd0, 1'b0);
      check_now("post_reset", SCR_MENU, 1'b0, 1'b0, 8'd0);
      frame_low(1); bus.btn_start = 1'b1; frame_low(5);
      tick(SCR_PLAY, 1'b1, 1'b1, 8'd0, 1'b1);
      bus.btn_start = 1'b0;
      step(5);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending_expectations got %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
